// File: rtl/dbg_pkg.sv
// Shared definitions for the debug-bus master: opcodes, sequencer
// states and DUMP argument field helpers.
package dbg_pkg;

    localparam logic [2:0] OP_RD_CYC = 3'd0;
    localparam logic [2:0] OP_RUN    = 3'd1;
    localparam logic [2:0] OP_STEP   = 3'd2;
    localparam logic [2:0] OP_HALT   = 3'd3;
    localparam logic [2:0] OP_READ   = 3'd4;
    localparam logic [2:0] OP_SET_BP = 3'd5;
    localparam logic [2:0] OP_CLR_BP = 3'd6;
    localparam logic [2:0] OP_DUMP   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_RD_WAIT,
        ST_RSP
    } state_t;

    function automatic logic [15:0] dump_base(input logic [31:0] arg);
        return arg[15:0];
    endfunction

    function automatic logic [15:0] dump_count(input logic [31:0] arg);
        return arg[31:16];
    endfunction

endpackage

// File: rtl/dbg_bp_cmp.sv
// Single PC breakpoint: address register, valid flag and comparator.
// Ports: clk, rst, set_bp/clr_bp strobes, bp_arg (new address),
// pc (write-back PC), bp_hit (valid && pc matches).
module dbg_bp_cmp #(
    parameter logic [31:0] BP_RESET_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_bp,
    input  logic        clr_bp,
    input  logic [31:0] bp_arg,
    input  logic [31:0] pc,
    output logic        bp_hit
);

    logic        bp_valid;
    logic [31:0] bp_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            bp_valid <= 1'b0;
            bp_addr  <= BP_RESET_VAL;
        end else if (set_bp) begin
            bp_valid <= 1'b1;
            bp_addr  <= bp_arg;
        end else if (clr_bp) begin
            bp_valid <= 1'b0;
        end
    end

    assign bp_hit = bp_valid && (pc == bp_addr);

endmodule

// File: rtl/dbg_ctrl.sv
// Debug-bus master: gates CPU execution (run/step/halt/breakpoint) and
// serves reads and address dumps from the debug read-out mux.
// Ports: clk, rst; cmd_valid/cmd_ready/cmd_op/cmd_arg command stream;
// rsp_valid/rsp_ready/rsp_data response stream; chk_addr/chk_data/chk_pc
// read-out mux side; cpu_en clock-enable; halted status.
// Optional: define DBG_CYCLE_CNT_EN for the RD_CYC cycle counter.
module dbg_ctrl #(
    parameter int unsigned READ_LAT     = 1,
    parameter logic [31:0] BP_RESET_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [15:0] chk_addr,
    input  logic [31:0] chk_data,
    input  logic [31:0] chk_pc,
    output logic        cpu_en,
    output logic        halted
);

    import dbg_pkg::*;

    localparam logic [2:0] LAT_MAX = 3'(READ_LAT);

    state_t      state_q, state_d;
    logic [15:0] chk_addr_q, chk_addr_d;
    logic [15:0] remain_q, remain_d;
    logic [2:0]  lat_q, lat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic        accept;
    logic        bp_hit;
    logic        set_bp;
    logic        clr_bp;
    logic [31:0] cyc_val;

    // Ready is masked during reset so nothing is accepted on that edge.
    assign cmd_ready = !rst &&
                       (state_q == ST_IDLE || state_q == ST_RUN);
    assign accept    = cmd_valid && cmd_ready;
    assign set_bp    = accept && (cmd_op == OP_SET_BP);
    assign clr_bp    = accept && (cmd_op == OP_CLR_BP);

    // Hit gates cpu_en in the same cycle so the matching instruction
    // stays in WB; a step ignores the breakpoint to move off it.
    assign cpu_en = (state_q == ST_STEP) ||
                    (state_q == ST_RUN && !bp_hit);
    assign halted = (state_q != ST_RUN);

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign chk_addr  = chk_addr_q;

    dbg_bp_cmp #(
        .BP_RESET_VAL(BP_RESET_VAL)
    ) u_bp (
        .clk    (clk),
        .rst    (rst),
        .set_bp (set_bp),
        .clr_bp (clr_bp),
        .bp_arg (cmd_arg),
        .pc     (chk_pc),
        .bp_hit (bp_hit)
    );

`ifdef DBG_CYCLE_CNT_EN
    logic [31:0] cyc_q;
    logic        run_start;

    assign run_start = accept && (state_q == ST_IDLE) &&
                       (cmd_op == OP_RUN);

    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            cyc_q <= '0;
        end else if (cpu_en) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign cyc_val = cyc_q;
`else
    assign cyc_val = '0;
`endif

    always_comb begin
        state_d     = state_q;
        chk_addr_d  = chk_addr_q;
        remain_d    = remain_q;
        lat_d       = lat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        OP_RUN:  state_d = ST_RUN;
                        OP_STEP: state_d = ST_STEP;
                        OP_READ: begin
                            chk_addr_d = cmd_arg[15:0];
                            remain_d   = 16'd1;
                            lat_d      = '0;
                            state_d    = ST_RD_WAIT;
                        end
                        OP_DUMP: begin
                            chk_addr_d = dump_base(cmd_arg);
                            remain_d   = dump_count(cmd_arg);
                            lat_d      = '0;
                            if (dump_count(cmd_arg) != '0) begin
                                state_d = ST_RD_WAIT;
                            end
                        end
                        OP_RD_CYC: begin
                            rsp_data_d  = cyc_val;
                            rsp_valid_d = 1'b1;
                            remain_d    = 16'd1;
                            state_d     = ST_RSP;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (bp_hit || (cmd_valid && cmd_op == OP_HALT)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                state_d = ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (lat_q == LAT_MAX) begin
                    rsp_data_d  = chk_data;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    remain_d    = remain_q - 16'd1;
                    if (remain_q != 16'd1) begin
                        chk_addr_d = chk_addr_q + 16'd1;
                        lat_d      = '0;
                        state_d    = ST_RD_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            chk_addr_q  <= '0;
            remain_q    <= '0;
            lat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            chk_addr_q  <= chk_addr_d;
            remain_q    <= remain_d;
            lat_q       <= lat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_dbg_ctrl.sv
// Self-checking bench for dbg_ctrl: directed command sequences plus
// a cycle model of run state, breakpoint and expected response queue.
module tb_dbg_ctrl;

    import dbg_pkg::*;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [15:0] chk_addr;
    logic [31:0] chk_data;
    logic [31:0] chk_pc;
    logic        cpu_en;
    logic        halted;

    int checks;
    int errors;

    dbg_ctrl #(
        .READ_LAT(1),
        .BP_RESET_VAL(32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .chk_addr  (chk_addr),
        .chk_data  (chk_data),
        .chk_pc    (chk_pc),
        .cpu_en    (cpu_en),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'h1003) return 32'hDEADBEEF;
        return {~a, a};
    endfunction

    // Synchronous read-out mux: one cycle of read latency.
    always @(posedge clk) begin
        if (rst) chk_data <= '0;
        else     chk_data <= mem_word(chk_addr);
    end

    // Toy CPU: WB PC advances by 4 on every enabled cycle.
    always @(posedge clk) begin
        if (rst)         chk_pc <= '0;
        else if (cpu_en) chk_pc <= chk_pc + 32'd4;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: is the CPU running, a step pending, the
    // breakpoint, cycles since RUN, and the words still owed to the host.
    bit          m_run;
    bit          m_step;
    bit          m_bpv;
    logic [31:0] m_bpa;
    logic [31:0] m_cyc;
    logic [31:0] m_q[$];

    always @(posedge clk) begin : model
        bit        hit;
        bit        en;
        bit        acc;
        bit        step_n;
        logic [15:0] base;
        logic [15:0] cnt;
        if (rsp_valid && rsp_ready && m_q.size() > 0) begin
            void'(m_q.pop_front());
        end
        if (rst) begin
            m_run  = 0;
            m_step = 0;
            m_bpv  = 0;
            m_bpa  = 32'h0;
            m_cyc  = 32'h0;
            m_q.delete();
        end else begin
            hit    = m_bpv && (chk_pc == m_bpa);
            en     = m_step || (m_run && !hit);
            acc    = cmd_valid && cmd_ready;
            step_n = 0;
            if (en) m_cyc = m_cyc + 32'd1;
            if (m_run && hit) m_run = 0;
            if (acc) begin
                case (cmd_op)
                    OP_RUN: if (!m_run && !m_step) begin
                        m_run = 1;
                        m_cyc = 32'h0;
                    end
                    OP_STEP: if (!m_run) step_n = 1;
                    OP_HALT: m_run = 0;
                    OP_SET_BP: begin
                        m_bpv = 1;
                        m_bpa = cmd_arg;
                    end
                    OP_CLR_BP: m_bpv = 0;
                    OP_READ: if (!m_run && !hit)
                        m_q.push_back(mem_word(cmd_arg[15:0]));
                    OP_DUMP: if (!m_run && !hit) begin
                        base = cmd_arg[15:0];
                        cnt  = cmd_arg[31:16];
                        for (int i = 0; i < int'(cnt); i++)
                            m_q.push_back(mem_word(base + 16'(i)));
                    end
                    default: if (!m_run && !hit) begin
`ifdef DBG_CYCLE_CNT_EN
                        m_q.push_back(m_cyc);
`else
                        m_q.push_back(32'h0);
`endif
                    end
                endcase
            end
            m_step = step_n;
        end
    end

    // Per-cycle comparison of DUT against the model.
    always @(negedge clk) begin : compare
        bit en_exp;
        if (!rst) begin
            en_exp = m_step ||
                     (m_run && !(m_bpv && chk_pc == m_bpa));
            chk("mdl_cpu_en", {31'b0, cpu_en}, {31'b0, en_exp});
            chk("mdl_halted", {31'b0, halted}, {31'b0, !m_run});
            if (rsp_valid) begin
                if (m_q.size() == 0)
                    chk("mdl_unexpected_rsp", rsp_data, 32'hxxxx_xxxx);
                else
                    chk("mdl_rsp_data", rsp_data, m_q[0]);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] arg);
        int n;
        n         = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_chk_addr"}, {16'b0, chk_addr}, 32'd0);
        chk({tag, "_cpu_en"}, {31'b0, cpu_en}, 32'd0);
        chk({tag, "_halted"}, {31'b0, halted}, 32'd1);
    endtask

    initial begin
        int n;
        int k;
        int cnt;
        logic [15:0] r_addr[4];
        logic [31:0] r_data[4];
        int          r_cyc[4];

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_HALT;
        cmd_arg   = '0;
        rsp_ready = 1'b1;
        checks    = 0;
        errors    = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single read with host back-pressure.
        rsp_ready = 1'b0;
        send(OP_READ, 32'h0000_1003);
        @(negedge clk);
        chk("rd_addr", {16'b0, chk_addr}, 32'h1003);
        chk("rd_c1_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rd_c1_ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("rd_c2_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rd_c3_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rd_c3_data", rsp_data, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rd_hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("rd_hold_data", rsp_data, 32'hDEADBEEF);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rd_hs_valid", {31'b0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("rd_drop_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rd_back_idle", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Dump across the 16-bit address wrap.
        send(OP_DUMP, {16'd3, 16'hFFFE});
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (rsp_valid && k < 4) begin
                r_addr[k] = chk_addr;
                r_data[k] = rsp_data;
                r_cyc[k]  = i;
                k++;
            end
        end
        chk("dump_count", k, 3);
        if (k == 3) begin
            chk("dump_a0", {16'b0, r_addr[0]}, 32'h0000FFFE);
            chk("dump_a1", {16'b0, r_addr[1]}, 32'h0000FFFF);
            chk("dump_a2", {16'b0, r_addr[2]}, 32'h00000000);
            chk("dump_d0", r_data[0], 32'h0001FFFE);
            chk("dump_d1", r_data[1], 32'h0000FFFF);
            chk("dump_d2", r_data[2], 32'hFFFF0000);
            chk("dump_first", r_cyc[0], 3);
            chk("dump_gap", r_cyc[2] - r_cyc[1], 3);
        end
        chk("dump_idle", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;

        send(OP_DUMP, {16'd0, 16'h1234});
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("dump0_rsp", cnt, 0);
        chk("dump0_addr", {16'b0, chk_addr}, 32'h1234);
        chk("dump0_idle", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Breakpoint at 0x10, then step off it.
        rst_pulse();
        send(OP_SET_BP, 32'h0000_0010);
        send(OP_RUN, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("bp_run_en", {31'b0, cpu_en}, 32'd1);
        end
        @(negedge clk);
        chk("bp_hit_en", {31'b0, cpu_en}, 32'd0);
        chk("bp_hit_halted", {31'b0, halted}, 32'd0);
        chk("bp_hit_pc", chk_pc, 32'h10);
        @(negedge clk);
        chk("bp_after_halted", {31'b0, halted}, 32'd1);
        chk("bp_after_pc", chk_pc, 32'h10);
        @(posedge clk);
        #1;
        send(OP_STEP, 32'h0);
        @(negedge clk);
        chk("step_en", {31'b0, cpu_en}, 32'd1);
        chk("step_ready", {31'b0, cmd_ready}, 32'd0);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (cpu_en) n++;
        end
        chk("step_extra", n, 0);
        chk("step_pc", chk_pc, 32'h14);
        @(posedge clk);
        #1;

        // RUN for seven cycles, HALT, read the cycle counter.
        send(OP_CLR_BP, 32'h0);
        send(OP_RUN, 32'h0);
        cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (cpu_en) cnt++;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b1;
        cmd_op    = OP_HALT;
        @(negedge clk);
        if (cpu_en) cnt++;
        chk("halt_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (cpu_en) cnt++;
        end
        chk("halt_en_cycles", cnt, 7);
        chk("halt_halted", {31'b0, halted}, 32'd1);
        @(posedge clk);
        #1;
        send(OP_RD_CYC, 32'h0);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rdcyc_valid", {31'b0, rsp_valid}, 32'd1);
`ifdef DBG_CYCLE_CNT_EN
        chk("rdcyc_data", rsp_data, 32'd7);
`else
        chk("rdcyc_data", rsp_data, 32'd0);
`endif
        @(posedge clk);
        #1;

        // READ while running is accepted and dropped.
        send(OP_RUN, 32'h0);
        cmd_valid = 1'b1;
        cmd_op    = OP_READ;
        cmd_arg   = 32'h0000_1003;
        @(negedge clk);
        chk("run_rd_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cnt = 0;
        n   = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
            if (halted) n++;
        end
        chk("run_rd_no_rsp", cnt, 0);
        chk("run_rd_still_run", n, 0);
        @(posedge clk);
        #1;
        send(OP_HALT, 32'h0);

        // Reset in the middle of a dump.
        send(OP_DUMP, {16'd4, 16'h0020});
        cnt = 0;
        n   = 0;
        while (cnt < 2 && n < 50) begin
            @(negedge clk);
            n++;
            if (rsp_valid) cnt++;
        end
        chk("mid_rsp_cnt", cnt, 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("mid_no_rsp", cnt, 0);
        chk("mid_idle", {31'b0, cmd_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/dbg_ctrl.md
Name: dbg_ctrl

Overview:
- Debug-bus master sitting directly upstream of the CPU debug read-out mux.
- Drives chk_addr and samples chk_data/chk_pc.
- Gates CPU execution: run, single-step, halt, one PC breakpoint.
- Serves single reads and sequential address dumps to a host-side command/response stream (UART bridge or testbench).

Parameters:
- READ_LAT, 1: cycles between chk_addr update and a valid chk_data sample (covers synchronous RF/IMU/DMU read ports); legal 0..7.
- BP_RESET_VAL, 32'h0: breakpoint address register value after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  3  opcode: 0 RD_CYC, 1 RUN, 2 STEP, 3 HALT, 4 READ, 5 SET_BP, 6 CLR_BP, 7 DUMP
- cmd_arg  in  32  READ: [15:0] addr; SET_BP: bp addr; DUMP: [15:0] base, [31:16] count
- rsp_valid  out  1  response word present
- rsp_ready  in  1  host consumes response
- rsp_data  out  32  response word
- chk_addr  out  16  debug address to read-out mux
- chk_data  in  32  debug data from read-out mux
- chk_pc  in  32  write-back-stage PC
- cpu_en  out  1  CPU clock-enable / pipeline advance
- halted  out  1  high when CPU not running

Behaviour:
- Reset values: cmd_ready 0, rsp_valid 0, rsp_data 0, chk_addr 0, cpu_en 0, halted 1, bp_valid 0, bp_addr BP_RESET_VAL, lat counter 0, state IDLE. Reset mid-dump or mid-run aborts silently with no response.
- States: IDLE, RUN, STEP, RD_WAIT, RSP.
- IDLE:
  - cmd_ready=1, every op accepted.
  - RUN → RUN.
  - STEP → STEP.
  - HALT: no-op.
  - SET_BP: bp_addr=arg, bp_valid=1.
  - CLR_BP: bp_valid=0.
  - READ: chk_addr=arg[15:0], remain=1, → RD_WAIT.
  - DUMP: chk_addr=base, remain=count; count==0 completes with no response, stays IDLE.
  - RD_CYC: rsp_data=cycle count, → RSP.
- RUN:
  - cmd_ready=1, halted=0.
  - cpu_en = !(bp_valid && chk_pc==bp_addr), combinational, so the matching instruction is held in WB.
  - On hit: → IDLE next cycle.
  - HALT → IDLE; cpu_en 0 from next cycle.
  - SET_BP/CLR_BP applied while running.
  - Any other op is accepted and dropped.
  - Simultaneous hit and HALT: single transition to IDLE.
- STEP:
  - cpu_en=1 for exactly one cycle, then IDLE.
  - Breakpoint is not checked on a step, so stepping off a breakpoint PC is possible.
  - cmd_ready=0.
- RD_WAIT:
  - cmd_ready=0; waits READ_LAT cycles (0 = sample the next cycle).
  - Then rsp_data=chk_data, rsp_valid=1, → RSP.
- RSP:
  - rsp_valid and rsp_data held stable until rsp_ready.
  - On handshake, remain decrements; if nonzero, chk_addr+1 (16-bit wrap FFFF→0000), → RD_WAIT; else → IDLE.
  - A rsp_valid&rsp_ready cycle drops rsp_valid next cycle, so responses arrive at most one per READ_LAT+2 cycles.
- chk_addr holds its last value in all other states.
- halted = (state != RUN).

Optional Feature:
- DBG_CYCLE_CNT_EN defined:
  - 32-bit counter increments each cycle cpu_en=1, wraps at 2^32.
  - Cleared by rst or by the RUN command.
  - RD_CYC returns its value.
- Not defined: no counter logic; RD_CYC returns 32'h0 through the normal RSP path.

Decomposition:
- Package dbg_pkg holds:
  - opcode localparams OP_RD_CYC..OP_DUMP
  - state encoding
  - DUMP field slices: base [15:0], count [31:16]
- One natural sub-module: dbg_bp_cmp, the breakpoint register plus comparator producing bp_hit.
- Sequencer and stream handshake stay in dbg_ctrl.

Test Plan:
- READ, arg=0x1003 (RF x3), READ_LAT=1, x3 preset 0xDEADBEEF → rsp_data 0xDEADBEEF exactly READ_LAT+1 cycles after accept; rsp_valid held while rsp_ready=0 for 5 cycles.
- DUMP, base=0xFFFE, count=3, rsp_ready always 1 → chk_addr sequence FFFE, FFFF, 0000; three responses in order, then IDLE; count=0 gives no response.
- SET_BP 0x0000_0010, then RUN; program reaches wb PC 0x10 → cpu_en low that same cycle, halted=1 next cycle, chk_pc stays 0x10; STEP → exactly one cpu_en pulse.
- RUN then HALT on cycle 7 → cpu_en high 7 cycles; RD_CYC returns 7 with DBG_CYCLE_CNT_EN, 0 without.
- During DUMP count=4, assert rst after second response → all outputs at reset values next cycle; no further rsp_valid.
- In RUN, issue READ → accepted (cmd_ready=1) and dropped: no rsp_valid, state stays RUN.
